conv1_ofmap_buffer: RTL
=======================

CONV1_OFMAP_BUFFER -- requirements
Module: conv1_ofmap_buffer

Interface
REQ-001 Parameter O_BW, default 16, pooled-result data width in bits (signed).
REQ-002 Parameter O_SIZE, default 12, pooled output side length per channel.
REQ-003 Parameter CO, default 4, number of output channels.
REQ-004 Parameter ADDR_W, default 10, buffer address width; SHALL satisfy 2**ADDR_W >= CO*O_SIZE*O_SIZE (576).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 ce  input  1  clock enable; low freezes all state, counters and output registers.
REQ-008 i_data  input  O_BW  signed pooled result from layer-1 producer.
REQ-009 i_en  input  1  i_data valid strobe.
REQ-010 i_ch_end  input  1  current channel complete.
REQ-011 i_allch_end  input  1  all channels complete.
REQ-012 i_rd_start  input  1  downstream layer requests readout.
REQ-013 o_data  output  O_BW  signed buffered result.
REQ-014 o_valid  output  1  o_data valid.
REQ-015 o_ch_end  output  1  high with last pixel of each channel on readout.
REQ-016 o_allch_end  output  1  high with final pixel of readout.
REQ-017 o_full  output  1  complete feature map stored, awaiting/under readout.
REQ-018 o_err  output  1  sticky protocol error flag.

Function
REQ-019 FSM states WRITE, FULL, READ; reset state WRITE.
REQ-020 WRITE: each cycle with ce&i_en SHALL write i_data at address ch*O_SIZE*O_SIZE + pix, then increment pix.
REQ-021 WRITE: ce&i_ch_end SHALL increment ch and clear pix; if i_en same cycle, the write completes first and counts toward the channel.
REQ-022 At i_ch_end, pix count (including same-cycle write) != O_SIZE*O_SIZE SHALL set o_err.
REQ-023 Writes when ch == CO SHALL be dropped and set o_err.
REQ-024 WRITE: ce&i_allch_end SHALL go FULL if ch (after same-cycle i_ch_end) == CO, else set o_err, clear ch/pix, stay WRITE.
REQ-025 FULL: o_full=1; i_en/i_ch_end/i_allch_end ignored and set o_err if asserted; ce&i_rd_start SHALL enter READ with rd_addr=0.
REQ-026 i_rd_start in WRITE or READ SHALL be ignored with no error.
REQ-027 READ: one address issued per ce cycle, 0..CO*O_SIZE*O_SIZE-1; memory read latency 1, output register 1.
REQ-028 First o_valid SHALL occur 2 ce-cycles after the cycle i_rd_start is accepted; with ce held high, 576 consecutive o_valid cycles.
REQ-029 o_ch_end SHALL coincide with o_valid of pix O_SIZE*O_SIZE-1 of each channel; o_allch_end with o_valid of the last entry (o_ch_end also high).
REQ-030 After last address issued, o_full SHALL drop; after last output, FSM SHALL return to WRITE with ch=pix=0.
REQ-031 o_data SHALL hold its last value when o_valid=0; o_valid/o_ch_end/o_allch_end are single-cycle pulses per ce cycle.

Reset
REQ-032 rst SHALL, at any state, force WRITE, ch=pix=rd_addr=0, o_data=0, o_valid=o_ch_end=o_allch_end=o_full=o_err=0 on the next edge, regardless of ce.
REQ-033 rst SHALL NOT clear buffer memory contents; readout after reset only occurs after a full refill.
REQ-034 o_err SHALL clear only on rst.

Structure
REQ-035 Shared package holds O_BW, O_SIZE, CO, derived DEPTH=CO*O_SIZE*O_SIZE and ADDR_W, FSM state encoding.
REQ-036 Storage SHALL be one instance of existing sp_bram (single port, registered read); write/read never overlap due to FSM.

Verification
REQ-037 Fill 4 channels x 144 values (value = ch*256+pix), ch_end each, allch_end -> o_full=1, o_err=0.
REQ-038 rd_start after fill, ce=1 -> first o_valid 2 cycles later, 576 values in order, o_ch_end at outputs 143/287/431/575, o_allch_end at 575, FSM back to WRITE.
REQ-039 Channel 1 ends after 143 pixels -> o_err=1 at that i_ch_end, stays 1 until rst.
REQ-040 ce toggled 50% during fill and readout -> identical data sequence to REQ-038, no missing/duplicated outputs.
REQ-041 rst asserted at readout output 300 -> next cycle all outputs 0, state WRITE; refill and readout give correct new data.
REQ-042 i_en with i_ch_end on pixel 143 of every channel -> pixel stored, no o_err, o_full after allch_end.

Source files
------------

// File: rtl/conv1_ofmap_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv1_ofmap_buffer_pkg
//  Purpose  : Shared constants and FSM encoding for the layer-1 output
//             feature-map buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package conv1_ofmap_buffer_pkg;

  localparam int c_O_BW   = 16;                       // pooled result width (signed)
  localparam int c_O_SIZE = 12;                       // pooled side length per channel
  localparam int c_CO     = 4;                        // output channels
  localparam int c_DEPTH  = c_CO * c_O_SIZE * c_O_SIZE; // stored words (576)
  localparam int c_ADDR_W = 10;                       // 2**10 >= 576

  typedef enum logic [1:0] {
    ST_WRITE = 2'd0,
    ST_FULL  = 2'd1,
    ST_READ  = 2'd2
  } state_e;

endpackage : conv1_ofmap_buffer_pkg
`default_nettype wire

// File: rtl/conv1_ofmap_buffer_bram.sv
`default_nettype none
// ============================================================================
//  Module   : sp_bram
//  Purpose  : Single-port block RAM with registered read data. Contents are
//             never reset so they survive a controller reset.
//  Revision : 1.0 - initial release
// ============================================================================
module sp_bram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Enabled port: write on i_we, otherwise register the addressed word.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule : sp_bram
`default_nettype wire

// File: rtl/conv1_ofmap_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : conv1_ofmap_buffer
//  Purpose  : Collects the pooled layer-1 feature map channel by channel,
//             flags protocol errors, then streams the whole map out in
//             address order when the next layer asks for it.
//  Revision : 1.0 - initial release
// ============================================================================
module conv1_ofmap_buffer
  import conv1_ofmap_buffer_pkg::*;
#(
  parameter int O_BW   = c_O_BW,
  parameter int O_SIZE = c_O_SIZE,
  parameter int CO     = c_CO,
  parameter int ADDR_W = c_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic signed [O_BW-1:0] i_data,
  input  logic                   i_en,
  input  logic                   i_ch_end,
  input  logic                   i_allch_end,
  input  logic                   i_rd_start,
  output logic signed [O_BW-1:0] o_data,
  output logic                   o_valid,
  output logic                   o_ch_end,
  output logic                   o_allch_end,
  output logic                   o_full,
  output logic                   o_err
);

  localparam int c_NPIX   = O_SIZE * O_SIZE;
  localparam int c_NWORDS = CO * c_NPIX;
  // Pixel counter keeps headroom above c_NPIX so an over-long channel is
  // still detected at its channel-end strobe.
  localparam int c_PIX_W  = $clog2(c_NPIX + 2);
  localparam int c_CH_W   = $clog2(CO + 1);

  localparam logic [c_PIX_W-1:0] c_PIX_FULL = c_PIX_W'(c_NPIX);
  localparam logic [c_PIX_W-1:0] c_PIX_LAST = c_PIX_W'(c_NPIX - 1);
  localparam logic [c_CH_W-1:0]  c_CH_DONE  = c_CH_W'(CO);
  localparam logic [ADDR_W-1:0]  c_ADDR_LAST = ADDR_W'(c_NWORDS - 1);

  state_e r_state;
  state_e w_state_nxt;

  logic [c_CH_W-1:0]  r_ch;
  logic [c_PIX_W-1:0] r_pix;
  logic               r_full;
  logic               r_err;

  logic [ADDR_W-1:0]  r_rd_addr;
  logic [c_PIX_W-1:0] r_rd_pix;
  logic               r_issue_done;
  logic               r_q_v;
  logic               r_q_ch_end;
  logic               r_q_last;

  logic signed [O_BW-1:0] r_data;
  logic                   r_valid;
  logic                   r_ch_end;
  logic                   r_allch_end;

  logic               w_ch_room;
  logic               w_wr;
  logic [c_PIX_W-1:0] w_pix_after;
  logic [c_CH_W-1:0]  w_ch_after;
  logic               w_alle_ok;
  logic               w_wr_err;
  logic               w_issue;
  logic               w_rd_last;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic               w_mem_we;
  logic [O_BW-1:0]    w_mem_q;

  // Write-side bookkeeping, read-issue qualifiers and the shared RAM port mux.
  always_comb begin
    w_ch_room   = (r_ch < c_CH_DONE);
    w_wr        = (r_state == ST_WRITE) && i_en && w_ch_room;
    w_pix_after = r_pix + c_PIX_W'(w_wr);
    w_ch_after  = (i_ch_end && w_ch_room) ? r_ch + c_CH_W'(1) : r_ch;
    w_alle_ok   = (w_ch_after == c_CH_DONE);
    w_wr_err    = (i_en && !w_ch_room)
                || (i_ch_end && (w_pix_after != c_PIX_FULL))
                || (i_allch_end && !w_alle_ok);
    w_issue     = (r_state == ST_READ) && !r_issue_done;
    w_rd_last   = (r_rd_addr == c_ADDR_LAST);
    w_wr_addr   = ADDR_W'(r_ch) * ADDR_W'(c_NPIX) + ADDR_W'(r_pix);
    w_mem_addr  = (r_state == ST_READ) ? r_rd_addr : w_wr_addr;
    w_mem_we    = w_wr && !rst;
  end

  // Next-state logic; every transition is qualified by ce.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WRITE: if (ce && i_allch_end && w_alle_ok) w_state_nxt = ST_FULL;
      ST_FULL:  if (ce && i_rd_start)               w_state_nxt = ST_READ;
      ST_READ:  if (ce && r_q_v && r_q_last)        w_state_nxt = ST_WRITE;
      default:                                      w_state_nxt = ST_WRITE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_WRITE;
    else     r_state <= w_state_nxt;
  end

  // Fill counters, sticky error and the full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch   <= '0;
      r_pix  <= '0;
      r_full <= 1'b0;
      r_err  <= 1'b0;
    end else if (ce) begin
      case (r_state)
        ST_WRITE: begin
          if (w_wr_err) r_err <= 1'b1;
          if (i_allch_end) begin
            r_ch  <= '0;
            r_pix <= '0;
            if (w_alle_ok) r_full <= 1'b1;
          end else if (i_ch_end) begin
            r_ch  <= w_ch_after;
            r_pix <= '0;
          end else begin
            r_pix <= w_pix_after;
          end
        end
        ST_FULL: begin
          if (i_en || i_ch_end || i_allch_end) r_err <= 1'b1;
        end
        ST_READ: begin
          if (w_issue && w_rd_last) r_full <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Read address generator and the flag pipeline aligned with RAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr    <= '0;
      r_rd_pix     <= '0;
      r_issue_done <= 1'b0;
      r_q_v        <= 1'b0;
      r_q_ch_end   <= 1'b0;
      r_q_last     <= 1'b0;
    end else if (ce) begin
      r_q_v      <= w_issue;
      r_q_ch_end <= w_issue && (r_rd_pix == c_PIX_LAST);
      r_q_last   <= w_issue && w_rd_last;
      if ((r_state == ST_FULL) && i_rd_start) begin
        r_rd_addr    <= '0;
        r_rd_pix     <= '0;
        r_issue_done <= 1'b0;
      end else if (w_issue) begin
        r_rd_addr <= r_rd_addr + ADDR_W'(1);
        r_rd_pix  <= (r_rd_pix == c_PIX_LAST) ? '0 : r_rd_pix + c_PIX_W'(1);
        if (w_rd_last) r_issue_done <= 1'b1;
      end
    end
  end

  // Output register: data holds between valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_ch_end    <= 1'b0;
      r_allch_end <= 1'b0;
    end else if (ce) begin
      r_valid     <= r_q_v;
      r_ch_end    <= r_q_v && r_q_ch_end;
      r_allch_end <= r_q_v && r_q_last;
      if (r_q_v) r_data <= $signed(w_mem_q);
    end
  end

  sp_bram #(
    .DATA_W (O_BW),
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk     (clk),
    .i_en    (ce),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (i_data),
    .o_rdata (w_mem_q)
  );

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_ch_end    = r_ch_end;
  assign o_allch_end = r_allch_end;
  assign o_full      = r_full;
  assign o_err       = r_err;

endmodule : conv1_ofmap_buffer
`default_nettype wire
